// File: rtl/tile_size_packer_pkg.sv
// tile_size_packer_pkg: shared constants, FSM encoding and record classification
package tile_size_packer_pkg;
  localparam int SIZE_W        = 7;
  localparam int RAW_BYTES_DEF = 64;
  localparam int ERR_OVF       = 0;
  localparam int ERR_UNEXP     = 1;
  localparam int ERR_RESTART   = 2;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  typedef struct packed {
    logic              mode;
    logic [SIZE_W-1:0] len;
  } rec_t;
  // Tiles that do not shrink below the raw payload are stored raw at full length
  function automatic rec_t classify(input logic [SIZE_W-1:0] size, input int raw);
    rec_t r;
    r.mode = int'(size) < raw;
    r.len  = r.mode ? size : SIZE_W'(raw);
    return r;
  endfunction
endpackage

// File: rtl/tile_size_packer_if.sv
// tile_size_packer_if: tile-size input pulses and header-record handshake
interface tile_size_packer_if #(parameter int IDX_W = 4, parameter int ADDR_W = 16);
  import tile_size_packer_pkg::*;
  logic              i_valid;
  logic [SIZE_W-1:0] all_data_byte_size;
  logic              o_ready;
  logic              o_valid;
  logic [IDX_W-1:0]  o_tile_idx;
  logic              o_mode;
  logic [SIZE_W-1:0] o_byte_len;
  logic [ADDR_W-1:0] o_byte_offset;
  modport master (output i_valid, all_data_byte_size, o_ready,
                  input  o_valid, o_tile_idx, o_mode, o_byte_len, o_byte_offset);
  modport slave  (input  i_valid, all_data_byte_size, o_ready,
                  output o_valid, o_tile_idx, o_mode, o_byte_len, o_byte_offset);
endinterface

// File: rtl/tile_size_packer_size_fifo.sv
// tile_size_packer_size_fifo: small synchronous FIFO with flush; a flushing push lands as sole entry
module tile_size_packer_size_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic [AW-1:0] w_wa;
  assign w_wa    = i_flush ? '0 : r_wr;
  assign o_data  = r_mem[r_rd];
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  // Pointer and occupancy tracking; flush restarts at slot 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= AW'(i_push);
      r_rd  <= '0;
      r_cnt <= (AW+1)'(i_push);
    end else begin
      r_wr  <= r_wr + AW'(i_push);
      r_rd  <= r_rd + AW'(i_pop);
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  // Storage needs no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wa] <= i_data;
  end
endmodule

// File: rtl/tile_size_packer.sv
// tile_size_packer: buffers per-tile sizes and emits mode/length/offset header records per frame
module tile_size_packer
  import tile_size_packer_pkg::*;
#(
  parameter int TILES_PER_FRAME = 16,
  parameter int RAW_BYTES       = RAW_BYTES_DEF,
  parameter int ADDR_W          = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  tile_size_packer_if.slave bus,
  output logic              frame_done,
  output logic [ADDR_W-1:0] frame_bytes,
  output logic [2:0]        err_flags
);
  localparam int IDX_W = $clog2(TILES_PER_FRAME);
  localparam int CNT_W = IDX_W + 1;
  state_t            r_state;
  logic [CNT_W-1:0]  r_acc;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_off, r_total;
  logic              r_valid, r_mode, r_done;
  logic [SIZE_W-1:0] r_len;
  logic [2:0]        r_err;
  logic [SIZE_W-1:0] w_head;
  logic              w_full, w_empty, w_take, w_push, w_pop, w_hs, w_last;
  logic              w_restart, w_unexp, w_ovf;
  rec_t              w_rec;
  assign w_restart = frame_start && r_state != IDLE;
  assign w_take    = bus.i_valid && (frame_start || r_state == ACTIVE);
  assign w_hs      = r_valid && bus.o_ready && !frame_start;
  assign w_pop     = !frame_start && !w_empty && (!r_valid || bus.o_ready);
  assign w_push    = w_take && (frame_start || !w_full || w_pop);
  assign w_ovf     = w_take && !w_push;
  assign w_unexp   = bus.i_valid && !frame_start && r_state != ACTIVE;
  assign w_last    = w_hs && r_idx == IDX_W'(TILES_PER_FRAME - 1);
  assign w_rec     = classify(w_head, RAW_BYTES);
  tile_size_packer_size_fifo #(.DEPTH(FIFO_DEPTH), .W(SIZE_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (frame_start),
    .i_data  (bus.all_data_byte_size),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // Frame FSM with accepted-tile count, handshake index, offset accumulator and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_idx   <= '0;
      r_off   <= '0;
      r_total <= '0;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_done <= w_last;
      r_err  <= r_err | {w_restart, w_unexp, w_ovf};
      if (frame_start) begin
        r_state <= ACTIVE;
        r_acc   <= CNT_W'(w_push);
        r_idx   <= '0;
        r_off   <= '0;
        r_total <= '0;
      end else begin
        if (w_push) r_acc <= r_acc + 1'b1;
        if (r_state == ACTIVE && w_push && r_acc == CNT_W'(TILES_PER_FRAME - 1)) r_state <= DRAIN;
        if (w_last) r_state <= IDLE;
        if (w_hs) begin
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          r_off <= w_last ? '0 : r_off + ADDR_W'(r_len);
        end
        if (w_last) r_total <= r_off + ADDR_W'(r_len);
      end
    end
  end
  // Output record register: refills from the FIFO head when free or on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_mode  <= 1'b0;
      r_len   <= '0;
    end else if (frame_start) begin
      r_valid <= 1'b0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_mode  <= w_rec.mode;
      r_len   <= w_rec.len;
    end else if (w_hs) begin
      r_valid <= 1'b0;
    end
  end
  assign bus.o_valid       = r_valid;
  assign bus.o_tile_idx    = r_idx;
  assign bus.o_mode        = r_mode;
  assign bus.o_byte_len    = r_len;
  assign bus.o_byte_offset = r_off;
  assign frame_done        = r_done;
  assign frame_bytes       = r_total;
  assign err_flags         = r_err;
endmodule

// File: tb/tb_tile_size_packer.sv
// tb_tile_size_packer: directed checks on a 4-tile instance and a 16-tile instance for FIFO overflow
module tb_tile_size_packer;
  logic        clk, rst_n, fs_a, fs_b;
  logic        done_a, done_b;
  logic [15:0] bytes_a, bytes_b;
  logic [2:0]  err_a, err_b;
  int          checks = 0;
  int          errors = 0;
  tile_size_packer_if #(.IDX_W(2), .ADDR_W(16)) a_if ();
  tile_size_packer_if #(.IDX_W(4), .ADDR_W(16)) b_if ();
  tile_size_packer #(.TILES_PER_FRAME(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .bus(a_if),
    .frame_done(done_a), .frame_bytes(bytes_a), .err_flags(err_a));
  tile_size_packer #(.TILES_PER_FRAME(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .bus(b_if),
    .frame_done(done_b), .frame_bytes(bytes_b), .err_flags(err_b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send_a(input logic [6:0] s);
    a_if.i_valid = 1'b1;
    a_if.all_data_byte_size = s;
    @(negedge clk);
    a_if.i_valid = 1'b0;
  endtask
  task automatic start_a();
    fs_a = 1'b1;
    @(negedge clk);
    fs_a = 1'b0;
  endtask
  task automatic wait_rec(input bit d, input string tag, input int idx, input int mode, input int len, input int off);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = d ? b_if.o_valid : a_if.o_valid;
    end
    check({tag, "_valid"}, 32'(got), 1);
    check({tag, "_idx"},  d ? 32'(b_if.o_tile_idx) : 32'(a_if.o_tile_idx), idx);
    check({tag, "_mode"}, d ? 32'(b_if.o_mode) : 32'(a_if.o_mode), mode);
    check({tag, "_len"},  d ? 32'(b_if.o_byte_len) : 32'(a_if.o_byte_len), len);
    check({tag, "_off"},  d ? 32'(b_if.o_byte_offset) : 32'(a_if.o_byte_offset), off);
  endtask
  task automatic quiet(input bit d, input string tag, input int n);
    int hits;
    hits = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (d ? b_if.o_valid : a_if.o_valid) hits++;
    end
    check(tag, hits, 0);
  endtask
  initial begin
    int bad;
    rst_n = 1'b0; fs_a = 1'b0; fs_b = 1'b0;
    a_if.i_valid = 1'b0; a_if.all_data_byte_size = '0; a_if.o_ready = 1'b1;
    b_if.i_valid = 1'b0; b_if.all_data_byte_size = '0; b_if.o_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(a_if.o_valid), 0);
    check("rst_err", 32'(err_a), 0);
    check("rst_bytes", 32'(bytes_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_valid_b", 32'(b_if.o_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    fs_b = 1'b1;
    @(negedge clk);
    fs_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b_if.i_valid = 1'b1;
      b_if.all_data_byte_size = 7'(10 + i);
      @(negedge clk);
    end
    b_if.i_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      if (!(b_if.o_valid === 1'b1 && b_if.o_byte_len === 7'd10 && b_if.o_mode === 1'b1 &&
            b_if.o_tile_idx === 4'd0 && b_if.o_byte_offset === 16'd0)) bad++;
    end
    check("stall_stable", bad, 0);
    check("ovf_err", 32'(err_b), 3'b001);
    b_if.o_ready = 1'b1;
    wait_rec(1'b1, "ovf_r1", 1, 1, 11, 10);
    wait_rec(1'b1, "ovf_r2", 2, 1, 12, 21);
    wait_rec(1'b1, "ovf_r3", 3, 1, 13, 33);
    wait_rec(1'b1, "ovf_r4", 4, 1, 14, 46);
    quiet(1'b1, "ovf_no_extra", 8);
    start_a();
    send_a(7'd20);
    wait_rec(1'b0, "f1_r0", 0, 1, 20, 0);
    repeat (14) @(negedge clk);
    send_a(7'd64);
    wait_rec(1'b0, "f1_r1", 1, 0, 64, 20);
    repeat (14) @(negedge clk);
    send_a(7'd70);
    wait_rec(1'b0, "f1_r2", 2, 0, 64, 84);
    repeat (14) @(negedge clk);
    send_a(7'd1);
    wait_rec(1'b0, "f1_r3", 3, 1, 1, 148);
    @(negedge clk);
    check("f1_done", 32'(done_a), 1);
    check("f1_bytes", 32'(bytes_a), 149);
    @(negedge clk);
    check("f1_done_pulse", 32'(done_a), 0);
    check("f1_err", 32'(err_a), 0);
    send_a(7'd50);
    quiet(1'b0, "idle_drop", 6);
    check("idle_err", 32'(err_a), 3'b010);
    start_a();
    a_if.i_valid = 1'b1;
    a_if.all_data_byte_size = 7'd33;
    @(negedge clk);
    a_if.i_valid = 1'b0;
    check("lat_early", 32'(a_if.o_valid), 0);
    @(negedge clk);
    check("lat_valid", 32'(a_if.o_valid), 1);
    check("lat_len", 32'(a_if.o_byte_len), 33);
    check("lat_mode", 32'(a_if.o_mode), 1);
    @(negedge clk);
    a_if.o_ready = 1'b0;
    send_a(7'd5);
    send_a(7'd6);
    send_a(7'd7);
    send_a(7'd9);
    wait_rec(1'b0, "dr_r1", 1, 1, 5, 33);
    a_if.o_ready = 1'b1;
    wait_rec(1'b0, "dr_r2", 2, 1, 6, 38);
    wait_rec(1'b0, "dr_r3", 3, 1, 7, 44);
    @(negedge clk);
    check("dr_done", 32'(done_a), 1);
    check("dr_bytes", 32'(bytes_a), 51);
    quiet(1'b0, "dr_no_extra", 8);
    check("dr_err", 32'(err_a), 3'b010);
    start_a();
    a_if.o_ready = 1'b0;
    send_a(7'd10);
    send_a(7'd11);
    @(negedge clk);
    check("rs_pre_valid", 32'(a_if.o_valid), 1);
    check("rs_pre_len", 32'(a_if.o_byte_len), 10);
    start_a();
    check("rs_flush_valid", 32'(a_if.o_valid), 0);
    check("rs_err", 32'(err_a), 3'b110);
    check("rs_bytes", 32'(bytes_a), 0);
    a_if.o_ready = 1'b1;
    send_a(7'd12);
    wait_rec(1'b0, "rs_r0", 0, 1, 12, 0);
    quiet(1'b0, "rs_no_stale", 6);
    a_if.o_ready = 1'b0;
    send_a(7'd20);
    @(negedge clk);
    check("ar_pre_valid", 32'(a_if.o_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(a_if.o_valid), 0);
    check("ar_idx", 32'(a_if.o_tile_idx), 0);
    check("ar_off", 32'(a_if.o_byte_offset), 0);
    check("ar_len", 32'(a_if.o_byte_len), 0);
    check("ar_err", 32'(err_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_if.o_ready = 1'b1;
    @(negedge clk);
    start_a();
    send_a(7'd63);
    wait_rec(1'b0, "f3_r0", 0, 1, 63, 0);
    send_a(7'd64);
    wait_rec(1'b0, "f3_r1", 1, 0, 64, 63);
    send_a(7'd0);
    wait_rec(1'b0, "f3_r2", 2, 1, 0, 127);
    send_a(7'd127);
    wait_rec(1'b0, "f3_r3", 3, 0, 64, 127);
    @(negedge clk);
    check("f3_done", 32'(done_a), 1);
    check("f3_bytes", 32'(bytes_a), 191);
    check("f3_err", 32'(err_a), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
